// File: rtl/fib_seq_engine.sv
// Multi-cycle Fibonacci engine: CHECK tests membership/index of a value, GEN produces F(n)
// with overflow detection, iterating one term per clock behind a start/done handshake.
module fib_seq_engine #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDXW-1:0]  index,
  output logic [WIDTH-1:0] fib_out,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   a, b, a_n, b_n, sum, tgt_x;
  logic [IDXW-1:0]  cnt, cnt_n, n_tgt, index_n;
  logic [WIDTH-1:0] tgt, fib_n;
  logic             md, ld, is_fib_n, ovf_n;

  // The extra top bit of a term is set exactly when it no longer fits in WIDTH bits.
  function automatic logic exceeds_max(input logic [WIDTH:0] v);
    return v[WIDTH];
  endfunction

  assign sum   = a + b;
  assign tgt_x = {1'b0, tgt};
  assign n_tgt = IDXW'(tgt);

  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    cnt_n    = cnt;
    ld       = 1'b0;
    is_fib_n = is_fib;
    index_n  = index;
    fib_n    = fib_out;
    ovf_n    = ovf;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld       = 1'b1;
          a_n      = '0;
          b_n      = {{WIDTH{1'b0}}, 1'b1};
          cnt_n    = '0;
          is_fib_n = 1'b0;
          index_n  = '0;
          fib_n    = '0;
          ovf_n    = 1'b0;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        if (!md) begin
          if (a == tgt_x) begin
            is_fib_n = 1'b1;
            index_n  = cnt;
            state_n  = S_DONE;
          end else if (a > tgt_x) begin
            is_fib_n = 1'b0;
            index_n  = cnt;
            state_n  = S_DONE;
          end else begin
            a_n   = b;
            b_n   = sum;
            cnt_n = cnt + 1'b1;
          end
        end else begin
          // Overflow wins over an index match so a too-large F(n) never leaks out truncated.
          if (exceeds_max(a)) begin
            ovf_n   = 1'b1;
            fib_n   = '0;
            state_n = S_DONE;
          end else if (cnt == n_tgt) begin
            fib_n   = a[WIDTH-1:0];
            state_n = S_DONE;
          end else begin
            a_n   = b;
            b_n   = sum;
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a       <= '0;
      b       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      is_fib  <= 1'b0;
      index   <= '0;
      fib_out <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      a       <= a_n;
      b       <= b_n;
      cnt     <= cnt_n;
      busy    <= (state_n == S_RUN);
      done    <= (state_n == S_DONE);
      is_fib  <= is_fib_n;
      index   <= index_n;
      fib_out <= fib_n;
      ovf     <= ovf_n;
    end
  end

  // Request operands are plain data captured on acceptance; they need no reset.
  always_ff @(posedge clk) begin
    if (ld) begin
      tgt <= in;
      md  <= mode;
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine at WIDTH=8 and WIDTH=16 with a queue-based scoreboard
// fed by a software Fibonacci model.
module tb_fib_seq_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, mode8, busy8, done8, is_fib8, ovf8;
  logic [7:0]  in8, fib8;
  logic [4:0]  index8;
  logic        start16, mode16, busy16, done16, is_fib16, ovf16;
  logic [15:0] in16, fib16;
  logic [4:0]  index16;

  always #5 clk = ~clk;

  fib_seq_engine #(.WIDTH(8), .IDXW(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .in(in8),
    .busy(busy8), .done(done8), .is_fib(is_fib8), .index(index8),
    .fib_out(fib8), .ovf(ovf8)
  );

  fib_seq_engine #(.WIDTH(16), .IDXW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .in(in16),
    .busy(busy16), .done(done16), .is_fib(is_fib16), .index(index16),
    .fib_out(fib16), .ovf(ovf16)
  );

  typedef struct {
    logic [63:0] is_fib;
    logic [63:0] index;
    logic [63:0] fib;
    logic [63:0] ovf;
    logic [63:0] lat;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Software model: walk the sequence until the termination rule for the mode fires.
  function automatic res_t model(input bit w16, input bit md, input longint vin);
    res_t   e;
    longint maxv = w16 ? 65535 : 255;
    longint fa = 0, fb = 1, t;
    int     k = 0;
    e.is_fib = 0; e.index = 0; e.fib = 0; e.ovf = 0;
    while (1) begin
      if (!md) begin
        if (fa >= vin) begin
          e.is_fib = (fa == vin) ? 1 : 0;
          e.index  = k;
          break;
        end
      end else begin
        if (fa > maxv) begin
          e.ovf = 1;
          break;
        end
        if (k == vin) begin
          e.fib = fa;
          break;
        end
      end
      t = fa + fb; fa = fb; fb = t; k++;
    end
    e.lat = k + 2;
    return e;
  endfunction

  function automatic logic get_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction

  function automatic logic get_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction

  // Called just after the edge that sampled start; latency counts clock edges to done.
  task automatic wait_done(input bit w16, output res_t o);
    res_t e;
    int   lat = 0, busyc = 0;
    bit   seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (get_done(w16)) seen = 1;
      else if (get_busy(w16)) busyc++;
    end
    chk("done_seen", seen, 1);
    o.is_fib = w16 ? is_fib16 : is_fib8;
    o.index  = w16 ? index16  : index8;
    o.fib    = w16 ? fib16    : fib8;
    o.ovf    = w16 ? ovf16    : ovf8;
    o.lat    = lat;
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("is_fib", o.is_fib, e.is_fib);
      chk("index", o.index, e.index);
      chk("fib_out", o.fib, e.fib);
      chk("ovf", o.ovf, e.ovf);
      chk("latency", o.lat, e.lat);
      chk("busy_cycles", busyc, e.lat - 1);
    end
    chk("busy_at_done", get_busy(w16), 0);
    @(negedge clk);
    chk("done_pulse", get_done(w16), 0);
  endtask

  task automatic do_req(input bit w16, input bit md, input longint vin, output res_t o);
    @(negedge clk);
    sb.push_back(model(w16, md, vin));
    if (w16) begin start16 = 1'b1; mode16 = md; in16 = 16'(vin); end
    else begin start8 = 1'b1; mode8 = md; in8 = 8'(vin); end
    @(posedge clk);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    wait_done(w16, o);
  endtask

  initial begin
    res_t o;
    int   nfib;
    rst_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; in8 = '0;
    start16 = 1'b0; mode16 = 1'b0; in16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_is_fib", is_fib8, 0);
    chk("rst_index", index8, 0);
    chk("rst_fib_out", fib8, 0);
    chk("rst_ovf", ovf8, 0);
    rst_n = 1'b1;

    // CHECK sweep over every 8-bit value
    nfib = 0;
    for (int v = 0; v < 256; v++) begin
      do_req(0, 0, v, o);
      if (o.is_fib == 1) nfib++;
      if (v == 1)   chk("chk1_index", o.index, 1);
      if (v == 4)   begin chk("chk4_index", o.index, 5); chk("chk4_lat", o.lat, 7); end
      if (v == 13)  begin chk("chk13_index", o.index, 7); chk("chk13_lat", o.lat, 9); end
      if (v == 255) begin chk("chk255_is_fib", o.is_fib, 0); chk("chk255_index", o.index, 14); end
    end
    chk("fib_member_count", nfib, 13);

    // GEN directed points
    do_req(0, 1, 0, o);  chk("gen0_fib", o.fib, 0);   chk("gen0_lat", o.lat, 2);
    do_req(0, 1, 1, o);  chk("gen1_fib", o.fib, 1);
    do_req(0, 1, 10, o); chk("gen10_fib", o.fib, 55); chk("gen10_lat", o.lat, 12);
    do_req(0, 1, 13, o); chk("gen13_fib", o.fib, 233); chk("gen13_ovf", o.ovf, 0);
    do_req(0, 1, 14, o); chk("gen14_ovf", o.ovf, 1);  chk("gen14_fib", o.fib, 0);

    // Mode switch: results of the CHECK run carry nothing over from GEN runs
    do_req(0, 1, 7, o);  chk("gen7_fib", o.fib, 13);
    do_req(0, 0, 13, o); chk("sw_is_fib", o.is_fib, 1); chk("sw_index", o.index, 7);
    chk("sw_fib_out", o.fib, 0); chk("sw_ovf", o.ovf, 0);

    // Handshake: start held high, operands changed mid-run
    @(negedge clk);
    sb.push_back(model(0, 0, 8));
    start8 = 1'b1; mode8 = 1'b0; in8 = 8'd8;
    @(posedge clk);
    #1;
    in8 = 8'd21; mode8 = 1'b1;
    sb.push_back(model(0, 1, 21));
    wait_done(0, o);
    chk("hs_index", o.index, 6);
    chk("hs_is_fib", o.is_fib, 1);
    chk("hs_busy_idle", busy8, 0);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("hs_accept_after_idle", busy8, 1);
    wait_done(0, o);
    chk("hs_second_ovf", o.ovf, 1);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; in8 = 8'd200;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_is_fib", is_fib8, 0);
    chk("arst_index", index8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nfib = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) nfib++;
    end
    chk("arst_no_done", nfib, 0);
    do_req(0, 0, 13, o); chk("arst_recover_index", o.index, 7);

    // WIDTH = 16 instance
    do_req(1, 0, 46368, o); chk("w16_chk_is_fib", o.is_fib, 1); chk("w16_chk_index", o.index, 24);
    do_req(1, 1, 24, o);    chk("w16_gen24", o.fib, 46368);
    do_req(1, 1, 25, o);    chk("w16_gen25_ovf", o.ovf, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
